splitter: RTL and testbench

- Decompression-side inverse of the merger; takes one packed word holding two variable-length tagged fields and emits each field separately.
- Input: packed data, a concatenated tag pair and a total byte length, over a valid/ready handshake.
- Output: one field per cycle, zero-extended, on a valid/ready stream to the downstream decoder.

---
 rtl/merge_pkg.sv | 27 ++
 rtl/byte_mask.sv | 20 ++
 rtl/splitter.sv | 124 ++++++++++++
 tb/tb_splitter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/merge_pkg.sv
// Shared definitions for the merger/splitter pair: tag codes, tag-to-length decode
// and the splitter state encoding.
package merge_pkg;

   localparam logic [1:0] TAG_ZERO = 2'b00;
   localparam logic [1:0] TAG_B1   = 2'b01;
   localparam logic [1:0] TAG_B2   = 2'b10;
   localparam logic [1:0] TAG_B4   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EMIT0 = 2'd1,
      EMIT1 = 2'd2
   } splitState_t;

   function automatic logic [2:0] tag_to_len(input logic [1:0] tag);
      logic [2:0] len;
      case (tag)
         TAG_ZERO: len = 3'd0;
         TAG_B1:   len = 3'd1;
         TAG_B2:   len = 3'd2;
         default:  len = 3'd4;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/byte_mask.sv
// Combinational byte mask: passes bytes below len, forces bytes at or above len to zero.
module byte_mask #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic [DATA_WIDTH-1:0] dataOut
);

   localparam int NBYTES = DATA_WIDTH / 8;

   always_comb begin
      dataOut = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (LEN_WIDTH'(i) < len) dataOut[8*i +: 8] = dataIn[8*i +: 8];
      end
   end

endmodule

// File: rtl/splitter.sv
// Splits one packed word holding two tagged variable-length fields into two output beats.
// Optional build macro SPLITTER_ERR_CNT_EN adds a saturating rejected-word counter errCnt.
module splitter
   import merge_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 2,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [2*DATA_WIDTH-1:0] dataIn,
   input  logic [2*TAG_WIDTH-1:0]  tagIn,
   input  logic [LEN_WIDTH-1:0]    lenIn,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [DATA_WIDTH-1:0]  dataOut,
   output logic [TAG_WIDTH-1:0]   tagOut,
   output logic [LEN_WIDTH-1:0]   lenOut,
`ifdef SPLITTER_ERR_CNT_EN
   output logic [15:0]            errCnt,
`endif
   output logic                   err
);

   splitState_t state, stateNext;

   logic [2*DATA_WIDTH-1:0] bufData;
   logic [TAG_WIDTH-1:0]    bufTag0, bufTag1;
   logic [LEN_WIDTH-1:0]    bufLen0, bufLen1;

   logic [LEN_WIDTH-1:0]    len0, len1;
   logic                    accept, sumOk, lastField, errNext;
   logic [DATA_WIDTH-1:0]   fieldRaw;
   logic [LEN_WIDTH-1:0]    fieldLen;

   assign len0  = LEN_WIDTH'(tag_to_len(tagIn[TAG_WIDTH-1:0]));
   assign len1  = LEN_WIDTH'(tag_to_len(tagIn[2*TAG_WIDTH-1:TAG_WIDTH]));
   assign sumOk = (len0 + len1) == lenIn;

   assign outValid  = (state != IDLE);
   assign lastField = (state == EMIT1) || ((state == EMIT0) && (bufLen1 == '0));
   // A word can be taken in the same cycle the last field of the previous one leaves.
   assign inReady   = (state == IDLE) || (outValid && outReady && lastField);
   assign accept    = inValid && inReady;
   assign errNext   = accept && !sumOk;

   always_comb begin
      stateNext = state;
      if (accept) begin
         if (!sumOk)              stateNext = IDLE;
         else if (len0 != '0)     stateNext = EMIT0;
         else if (len1 != '0)     stateNext = EMIT1;
         else                     stateNext = IDLE;
      end else if (outReady) begin
         case (state)
            EMIT0:   stateNext = (bufLen1 != '0) ? EMIT1 : IDLE;
            EMIT1:   stateNext = IDLE;
            default: stateNext = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         err   <= 1'b0;
      end else begin
         state <= stateNext;
         err   <= errNext;
      end
   end

   // Buffer is never observed outside EMIT states, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         bufData <= dataIn;
         bufTag0 <= tagIn[TAG_WIDTH-1:0];
         bufTag1 <= tagIn[2*TAG_WIDTH-1:TAG_WIDTH];
         bufLen0 <= len0;
         bufLen1 <= len1;
      end
   end

`ifdef SPLITTER_ERR_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          errCnt <= '0;
      else if (errNext && errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
   end
`endif

   always_comb begin
      fieldRaw = '0;
      fieldLen = '0;
      tagOut   = '0;
      case (state)
         EMIT0: begin
            fieldRaw = bufData[DATA_WIDTH-1:0];
            fieldLen = bufLen0;
            tagOut   = bufTag0;
         end
         EMIT1: begin
            fieldRaw = DATA_WIDTH'(bufData >> {bufLen0, 3'b000});
            fieldLen = bufLen1;
            tagOut   = bufTag1;
         end
         default: ;
      endcase
   end

   assign lenOut = fieldLen;

   byte_mask #(
      .DATA_WIDTH(DATA_WIDTH),
      .LEN_WIDTH (LEN_WIDTH)
   ) uMask (
      .dataIn (fieldRaw),
      .len    (fieldLen),
      .dataOut(dataOut)
   );

endmodule

// File: tb/tb_splitter.sv
// Directed self-checking bench for splitter; inputs change 1 time unit after posedge,
// outputs are sampled on the falling edge.
module tb_splitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [63:0] dataIn;
   logic [3:0]  tagIn;
   logic [7:0]  lenIn;
   logic        outValid;
   logic        outReady;
   logic [31:0] dataOut;
   logic [1:0]  tagOut;
   logic [7:0]  lenOut;
   logic        err;
`ifdef SPLITTER_ERR_CNT_EN
   logic [15:0] errCnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   splitter #(.DATA_WIDTH(32), .TAG_WIDTH(2), .LEN_WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .inValid (inValid),
      .inReady (inReady),
      .dataIn  (dataIn),
      .tagIn   (tagIn),
      .lenIn   (lenIn),
      .outValid(outValid),
      .outReady(outReady),
      .dataOut (dataOut),
      .tagOut  (tagOut),
      .lenOut  (lenOut),
`ifdef SPLITTER_ERR_CNT_EN
      .errCnt  (errCnt),
`endif
      .err     (err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic checkField(input string tag, input logic [31:0] d, input logic [1:0] t,
                             input logic [7:0] l);
      check({tag, ".valid"}, 64'(outValid), 64'd1);
      check({tag, ".data"},  64'(dataOut),  64'(d));
      check({tag, ".tag"},   64'(tagOut),   64'(t));
      check({tag, ".len"},   64'(lenOut),   64'(l));
   endtask

   initial begin
      reset    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      dataIn   = '0;
      tagIn    = '0;
      lenIn    = '0;

      // reset state
      sample();
      check("rst.outValid", 64'(outValid), 64'd0);
      check("rst.dataOut",  64'(dataOut),  64'd0);
      check("rst.tagOut",   64'(tagOut),   64'd0);
      check("rst.lenOut",   64'(lenOut),   64'd0);
      check("rst.err",      64'(err),      64'd0);
      drive();
      reset = 1'b1;
      sample();
      check("rst.inReady", 64'(inReady), 64'd1);

      // two-field word, outReady high
      drive();
      inValid = 1'b1; dataIn = 64'h0000_4321_CBA9_8765; tagIn = 4'b1011; lenIn = 8'd6;
      sample();
      check("w1.inReadyIdle", 64'(inReady), 64'd1);
      drive();
      inValid = 1'b0;
      sample();
      checkField("w1.f0", 32'hCBA9_8765, 2'b11, 8'd4);
      check("w1.f0.err", 64'(err), 64'd0);
      check("w1.f0.inReady", 64'(inReady), 64'd0);
      sample();
      checkField("w1.f1", 32'h0000_4321, 2'b10, 8'd2);
      check("w1.f1.inReady", 64'(inReady), 64'd1);
      check("w1.f1.err", 64'(err), 64'd0);
      sample();
      check("w1.idle", 64'(outValid), 64'd0);

      // backpressure for three cycles on the first field
      drive();
      inValid = 1'b1; outReady = 1'b0;
      drive();
      inValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         checkField($sformatf("bp.hold%0d", i), 32'hCBA9_8765, 2'b11, 8'd4);
         check($sformatf("bp.inReady%0d", i), 64'(inReady), 64'd0);
         drive();
      end
      outReady = 1'b1;
      sample();
      checkField("bp.f0rel", 32'hCBA9_8765, 2'b11, 8'd4);
      sample();
      checkField("bp.f1", 32'h0000_4321, 2'b10, 8'd2);
      sample();
      check("bp.idle", 64'(outValid), 64'd0);

      // single one-byte field
      drive();
      inValid = 1'b1; dataIn = 64'hFFFF_FFFF_FFFF_FFAB; tagIn = 4'b0001; lenIn = 8'd1;
      drive();
      inValid = 1'b0;
      sample();
      checkField("one.f0", 32'h0000_00AB, 2'b01, 8'd1);
      check("one.inReady", 64'(inReady), 64'd1);
      sample();
      check("one.idle", 64'(outValid), 64'd0);

      // length mismatch rejected
      drive();
      inValid = 1'b1; dataIn = 64'h0000_4321_CBA9_8765; tagIn = 4'b1011; lenIn = 8'd5;
      drive();
      inValid = 1'b0;
      sample();
      check("bad.err", 64'(err), 64'd1);
      check("bad.outValid", 64'(outValid), 64'd0);
`ifdef SPLITTER_ERR_CNT_EN
      check("bad.errCnt", 64'(errCnt), 64'd1);
`endif
      sample();
      check("bad.errPulse", 64'(err), 64'd0);
      check("bad.outValid2", 64'(outValid), 64'd0);

      // back-to-back words
      drive();
      inValid = 1'b1; dataIn = 64'h0000_4321_CBA9_8765; tagIn = 4'b1011; lenIn = 8'd6;
      drive();
      dataIn = 64'h5555_5555_5555_2211; tagIn = 4'b0101; lenIn = 8'd2;
      sample();
      checkField("b2b.a0", 32'hCBA9_8765, 2'b11, 8'd4);
      check("b2b.a0.inReady", 64'(inReady), 64'd0);
      sample();
      checkField("b2b.a1", 32'h0000_4321, 2'b10, 8'd2);
      check("b2b.a1.inReady", 64'(inReady), 64'd1);
      drive();
      inValid = 1'b0;
      sample();
      checkField("b2b.b0", 32'h0000_0011, 2'b01, 8'd1);
      sample();
      checkField("b2b.b1", 32'h0000_0022, 2'b01, 8'd1);
      sample();
      check("b2b.idle", 64'(outValid), 64'd0);

      // reset while holding the first field
      drive();
      inValid = 1'b1; outReady = 1'b0;
      dataIn = 64'h0000_4321_CBA9_8765; tagIn = 4'b1011; lenIn = 8'd6;
      drive();
      inValid = 1'b0;
      sample();
      checkField("mid.f0", 32'hCBA9_8765, 2'b11, 8'd4);
      #2;
      reset = 1'b0;
      #1;
      check("mid.outValid", 64'(outValid), 64'd0);
      check("mid.dataOut",  64'(dataOut),  64'd0);
      drive();
      reset = 1'b1;
      outReady = 1'b1;
      sample();
      check("mid.inReady", 64'(inReady), 64'd1);
      check("mid.noStale", 64'(outValid), 64'd0);
      sample();
      check("mid.noStale2", 64'(outValid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
